// File: rtl/osc_result_framer_pkg.sv
// osc_result_framer_pkg: shared ASCII constants, framer state type and frame-length helper
package osc_result_framer_pkg;
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] CHR_H   = 8'h48;
  localparam logic [7:0] CHR_R   = 8'h52;
  function automatic int frame_len(input int num_ch, input int cnt_w, input int seq_w);
    return seq_w / 4 + 1 + num_ch * (cnt_w / 4 + 1) + 3;
  endfunction
endpackage

// File: rtl/osc_result_framer_hex.sv
// osc_hex_nibble: 4-bit value to uppercase ASCII hex digit (nib_i in, chr_o out)
module osc_hex_nibble
  import osc_result_framer_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] chr_o
);
  assign chr_o = (nib_i < 4'd10) ? ASCII_0 + {4'h0, nib_i} : ASCII_A + {4'h0, nib_i} - 8'd10;
endmodule

// File: rtl/osc_result_framer.sv
// osc_result_framer: formats one latched oscillator sample as an ASCII line and streams it bytewise.
//   ref_clk/rstn: clock, async active-low reset
//   smpl_valid_i/smpl_data_i/smpl_halt_i/smpl_ready_o: sample strobe input side
//   byte_valid_o/byte_data_o/byte_ready_i: byte stream to the UART
//   frame_busy_o: line in progress; drop_cnt_o: saturating count of strobes lost while busy
module osc_result_framer
  import osc_result_framer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int SEQ_W  = 8,
  parameter int DROP_W = 8
) (
  input  logic                    ref_clk,
  input  logic                    rstn,
  input  logic                    smpl_valid_i,
  input  logic [NUM_CH*CNT_W-1:0] smpl_data_i,
  input  logic                    smpl_halt_i,
  output logic                    smpl_ready_o,
  output logic                    byte_valid_o,
  output logic [7:0]              byte_data_o,
  input  logic                    byte_ready_i,
  output logic                    frame_busy_o,
  output logic [DROP_W-1:0]       drop_cnt_o
);
  localparam int SN    = SEQ_W / 4;
  localparam int CN    = CNT_W / 4;
  localparam int LEN   = frame_len(NUM_CH, CNT_W, SEQ_W);
  localparam int IDX_W = $clog2(LEN + 1);
  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SEQ_W-1:0]        seq_q, sh_seq_q;
  logic [NUM_CH*CNT_W-1:0] sh_data_q;
  logic                    sh_halt_q;
  logic [DROP_W-1:0]       drop_q;
  logic                    accept, last;
  logic [3:0]              nib;
  logic                    is_hex;
  logic [7:0]              chr, hex_chr;
  assign frame_busy_o = state_q != IDLE;
  assign smpl_ready_o = !frame_busy_o;
  assign byte_valid_o = frame_busy_o;
  assign accept       = smpl_valid_i && smpl_ready_o;
  assign last         = idx_q == IDX_W'(LEN - 1);
  assign drop_cnt_o   = drop_q;
  assign byte_data_o  = byte_valid_o ? (is_hex ? hex_chr : chr) : 8'h00;
  osc_hex_nibble u_hex (.nib_i(nib), .chr_o(hex_chr));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == IDLE && smpl_valid_i) begin
      state_d = EMIT;
      idx_d   = '0;
    end else if (state_q == EMIT && byte_ready_i) begin
      state_d = last ? IDLE : EMIT;
      idx_d   = last ? '0 : idx_q + IDX_W'(1);
    end
  end
  // Field decoder: byte index -> either a hex nibble of seq/channel or a fixed character.
  always_comb begin
    int i, b;
    i      = 32'(idx_q);
    b      = 0;
    nib    = '0;
    is_hex = 1'b0;
    chr    = 8'h00;
    if (i < SN) begin
      is_hex = 1'b1;
      nib    = sh_seq_q[(SN-1-i)*4 +: 4];
    end
    if (i == SN) chr = COLON;
    for (int c = 0; c < NUM_CH; c++) begin
      b = SN + 1 + c * (CN + 1);
      if (i >= b && i < b + CN) begin
        is_hex = 1'b1;
        nib    = sh_data_q[c*CNT_W + (CN-1-(i-b))*4 +: 4];
      end
      if (i == b + CN) chr = SPACE;
    end
    if (i == LEN - 3) chr = sh_halt_q ? CHR_H : CHR_R;
    if (i == LEN - 2) chr = CR;
    if (i == LEN - 1) chr = LF;
  end
  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      seq_q     <= '0;
      sh_seq_q  <= '0;
      sh_data_q <= '0;
      sh_halt_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        sh_seq_q  <= seq_q;
        sh_data_q <= smpl_data_i;
        sh_halt_q <= smpl_halt_i;
        seq_q     <= seq_q + SEQ_W'(1);
      end
      if (smpl_valid_i && !smpl_ready_o && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
    end
  end
endmodule

// File: tb/tb_osc_result_framer.sv
// tb_osc_result_framer: randomized and directed checks of osc_result_framer against a line-building model
module tb_osc_result_framer;
  localparam int L = 24;
  localparam logic [63:0] D1 = {32'h1234ABCD, 32'h0098967F};
  logic        clk = 1'b0, rstn = 1'b0;
  logic        sv = 1'b0, sh = 1'b0, br = 1'b0;
  logic [63:0] sd = '0;
  logic        smpl_ready_o, byte_valid_o, frame_busy_o;
  logic [7:0]  byte_data_o, drop_cnt_o;
  int pass_n = 0, tot_n = 0;
  always #5 clk = ~clk;
  osc_result_framer dut (
    .ref_clk(clk), .rstn(rstn), .smpl_valid_i(sv), .smpl_data_i(sd), .smpl_halt_i(sh),
    .smpl_ready_o(smpl_ready_o), .byte_valid_o(byte_valid_o), .byte_data_o(byte_data_o),
    .byte_ready_i(br), .frame_busy_o(frame_busy_o), .drop_cnt_o(drop_cnt_o)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  logic [7:0] mq[$];
  int         midx;
  bit         mbusy;
  logic [7:0] mseq, mdrop;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mbusy = 0; midx = 0; mseq = 0; mdrop = 0; mq.delete();
    end else if (!mbusy) begin
      if (sv) begin
        mq.delete();
        for (int k = 1; k >= 0; k--) mq.push_back(hx(mseq[k*4 +: 4]));
        mq.push_back(8'h3A);
        for (int c = 0; c < 2; c++) begin
          for (int k = 7; k >= 0; k--) mq.push_back(hx(sd[c*32 + k*4 +: 4]));
          mq.push_back(8'h20);
        end
        mq.push_back(sh ? 8'h48 : 8'h52);
        mq.push_back(8'h0D);
        mq.push_back(8'h0A);
        mseq++; mbusy = 1; midx = 0;
      end
    end else begin
      if (sv && mdrop != 8'hFF) mdrop++;
      if (br) begin
        midx++;
        if (midx == L) mbusy = 0;
      end
    end
  end
  logic [7:0] ln[$], lq[$];
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pb = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      ln.delete(); pv <= 1'b0;
    end else begin
      chk("valid", byte_valid_o, mbusy);
      chk("data", byte_data_o, mbusy ? mq[midx] : 8'h00);
      chk("ready", smpl_ready_o, !mbusy);
      chk("busy", frame_busy_o, mbusy);
      chk("drop", drop_cnt_o, mdrop);
      if (pv && !pr) chk("hold", {byte_valid_o, byte_data_o}, {1'b1, pb});
      if (byte_valid_o && br) begin
        ln.push_back(byte_data_o);
        if (byte_data_o == 8'h0A) begin lq = ln; ln.delete(); end
      end
      pv <= byte_valid_o; pr <= br; pb <= byte_data_o;
    end
  end
  task automatic chk_line(input string nm, input string body);
    logic [7:0] e[$];
    string a = "", x = "";
    bit ok;
    for (int i = 0; i < body.len(); i++) e.push_back(body[i]);
    e.push_back(8'h0D); e.push_back(8'h0A);
    ok = e.size() == lq.size();
    for (int i = 0; i < e.size() && ok; i++) if (e[i] !== lq[i]) ok = 0;
    tot_n++;
    if (ok) pass_n++;
    else begin
      foreach (lq[i]) a = {a, $sformatf("%02h", lq[i])};
      foreach (e[i]) x = {x, $sformatf("%02h", e[i])};
      $display("FAIL %s: got %s expected %s", nm, a, x);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    br = 1'b1;
    while (!smpl_ready_o && n < 3000) begin @(posedge clk); #1; n++; end
    chk("idle_reached", smpl_ready_o, 1'b1);
  endtask
  task automatic run_frame(input logic [63:0] d, input bit h, input int mode, output int n);
    sd = d; sh = h; sv = 1'b1; br = 1'b1;
    @(posedge clk); #1 sv = 1'b0;
    n = 0;
    while (!smpl_ready_o && n < 3000) begin
      br = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 3 == 2) : 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    chk("frame_done", smpl_ready_o, 1'b1);
  endtask
  initial begin
    int n;
    #1;
    chk("rst_valid", byte_valid_o, 1'b0);
    chk("rst_data", byte_data_o, 8'h00);
    chk("rst_ready", smpl_ready_o, 1'b1);
    chk("rst_busy", frame_busy_o, 1'b0);
    chk("rst_drop", drop_cnt_o, 8'h00);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    sd = D1; sh = 1'b0; sv = 1'b1; br = 1'b1;
    @(posedge clk); #1 sv = 1'b0;
    chk("t1_first_valid", {byte_valid_o, byte_data_o}, {1'b1, 8'h30});
    n = 0;
    while (!smpl_ready_o && n < 100) begin @(posedge clk); #1; n++; end
    chk("t1_latency", n, 24);
    chk_line("t1_line", "00:0098967F 1234ABCD R");
    run_frame(D1, 1'b0, 1, n);
    chk_line("t2_line", "01:0098967F 1234ABCD R");
    sd = D1; sv = 1'b1; br = 1'b1;
    @(posedge clk); #1 sv = 1'b0;
    repeat (23) begin @(posedge clk); #1; end
    chk("t6_lf_valid", byte_data_o, 8'h0A);
    sv = 1'b1;
    @(posedge clk); #1;
    chk("t6_drop", drop_cnt_o, 8'd1);
    chk("t6_ready", smpl_ready_o, 1'b1);
    @(posedge clk); #1 sv = 1'b0;
    chk("t6_first", {byte_valid_o, byte_data_o}, {1'b1, 8'h30});
    wait_idle();
    chk_line("t6_line", "03:0098967F 1234ABCD R");
    sd = D1; sv = 1'b1; br = 1'b1;
    @(posedge clk); #1 sv = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    sv = 1'b1; sd = 64'hFFFF_FFFF_FFFF_FFFF; sh = 1'b1;
    @(posedge clk); #1 sv = 1'b0;
    chk("t3_drop1", drop_cnt_o, 8'd2);
    wait_idle();
    chk_line("t3_line", "04:0098967F 1234ABCD R");
    sd = D1; sh = 1'b0; sv = 1'b1; br = 1'b0;
    @(posedge clk); #1;
    repeat (300) begin @(posedge clk); #1; end
    sv = 1'b0;
    chk("t3_drop_sat", drop_cnt_o, 8'hFF);
    wait_idle();
    chk_line("t3_line2", "05:0098967F 1234ABCD R");
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int f = 0; f < 257; f++) begin
      run_frame({$urandom, $urandom}, 1'b1, 0, n);
      chk("t4_tail", {lq[lq.size()-3], lq[lq.size()-2], lq[lq.size()-1]}, {8'h48, 8'h0D, 8'h0A});
      if (f == 255) chk("t4_head255", {lq[0], lq[1], lq[2]}, {8'h46, 8'h46, 8'h3A});
      if (f == 256) chk("t4_head256", {lq[0], lq[1], lq[2]}, {8'h30, 8'h30, 8'h3A});
    end
    sd = D1; sv = 1'b1; br = 1'b1;
    @(posedge clk); #1 sv = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    chk("t5_byte7", {byte_valid_o, byte_data_o}, {1'b1, 8'h39});
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_valid", byte_valid_o, 1'b0);
    chk("t5_async_data", byte_data_o, 8'h00);
    chk("t5_async_ready", smpl_ready_o, 1'b1);
    @(posedge clk); #1 rstn = 1'b1;
    chk("t5_ready_after", smpl_ready_o, 1'b1);
    run_frame(D1, 1'b0, 2, n);
    chk_line("t5_line", "00:0098967F 1234ABCD R");
    repeat (3000) begin
      sv = $urandom_range(0, 7) == 0;
      sd = {$urandom, $urandom};
      sh = 1'($urandom_range(0, 1));
      br = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    sv = 1'b0;
    wait_idle();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
